serial_frame_tx: RTL

Serial frame transmitter: the sending end of the one-wire port/length/data serial link. Accepts a parallel frame (destination port, bit count, payload) through a valid/ready handshake. Emits it bit-serially on `SerOut` at the `clkEn` tick rate: start bit 0, port field, length field, payload bits, stop bit 1. Sits in front of the serial demux receiver and drives its `SerIn` line.

---
 rtl/serial_pkg.sv | 28 ++
 rtl/serial_tx_shifter.sv | 48 ++++
 rtl/serial_frame_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the port/length/data serial link (transmitter and receiver).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_pkg;

    localparam int SERIAL_PORT_W = 2;
    localparam int SERIAL_LEN_W  = 4;
    localparam int SERIAL_DATA_W = 2**SERIAL_LEN_W - 1;

    // Line states; PAR is only reachable when the parity bit is built in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_PORT  = 3'd3,
        ST_LEN   = 3'd4,
        ST_DATA  = 3'd5,
        ST_PAR   = 3'd6,
        ST_STOP  = 3'd7
    } state_e;

    typedef struct packed {
        logic [SERIAL_PORT_W-1:0] port;
        logic [SERIAL_LEN_W-1:0]  len;
        logic [SERIAL_DATA_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/serial_tx_shifter.sv
// Frame shift register (MSB out, shift-left) plus per-field bit down-counter.
// Latency: load/shift/decrement take effect on the next clk edge.
// Backpressure: none; the FSM decides when to load, shift and count.
module serial_tx_shifter #(
    parameter int SR_W  = 21,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sr_load_i,
    input  logic [SR_W-1:0]  sr_dat_i,
    input  logic             sr_shift_i,
    input  logic             cnt_load_i,
    input  logic [CNT_W-1:0] cnt_dat_i,
    input  logic             cnt_dec_i,
    output logic             sr_msb_o,
    output logic             cnt_zero_o
);

    logic [SR_W-1:0]  sr_q;
    logic [CNT_W-1:0] cnt_q;

    // Shift register: a load replaces the whole frame, otherwise shift one bit toward the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else if (sr_load_i) begin
            sr_q <= sr_dat_i;
        end else if (sr_shift_i) begin
            sr_q <= {sr_q[SR_W-2:0], 1'b0};
        end
    end

    // Bit counter: loaded with (field width - 1), counts down once per sent bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_load_i) begin
            cnt_q <= cnt_dat_i;
        end else if (cnt_dec_i) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign sr_msb_o   = sr_q[SR_W-1];
    assign cnt_zero_o = (cnt_q == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start 0, port, length, N payload bits, [parity], stop 1 on SerOut; SERTX_PARITY_EN adds an even-parity bit.
// Latency: start bit on the second clkEn tick after acceptance; frame is 1+PORT_W+LEN_W+N+1 ticks (+1 with parity).
// Backpressure: InReady only in IDLE; InValid is ignored while a frame is in flight, InReady returns with Done.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int PORT_W = SERIAL_PORT_W,
    parameter int LEN_W  = SERIAL_LEN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clkEn,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [PORT_W-1:0]     PortIn,
    input  logic [LEN_W-1:0]      LenIn,
    input  logic [2**LEN_W-2:0]   DataIn,
    output logic                  SerOut,
    output logic                  Busy,
    output logic                  Done
);

    localparam int DATA_W = 2**LEN_W - 1;
    localparam int SR_W   = PORT_W + LEN_W + DATA_W;
    localparam int CNT_W  = (LEN_W > PORT_W) ? LEN_W : PORT_W;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q;
    logic              done_q, done_d;
    logic              accept;
    logic [DATA_W-1:0] data_aligned;
    logic              sr_load, sr_shift, cnt_load, cnt_dec;
    logic [CNT_W-1:0]  cnt_dat;
    logic              sr_msb, cnt_zero;
    state_e            after_payload;

    assign accept = (state_q == ST_IDLE) && InValid;

    // Left-justify the payload so bit N-1 leaves first; unsent upper bits fall off the top.
    always_comb data_aligned = DataIn << (LEN_W'(DATA_W) - LenIn);

`ifdef SERTX_PARITY_EN
    logic parity_q;

    // Even parity over port, length and the sent payload bits, fixed at capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^{PortIn, LenIn, data_aligned};
        end
    end

    assign after_payload = ST_PAR;
`else
    assign after_payload = ST_STOP;
`endif

    serial_tx_shifter #(
        .SR_W  (SR_W),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .sr_load_i  (sr_load),
        .sr_dat_i   ({PortIn, LenIn, data_aligned}),
        .sr_shift_i (sr_shift),
        .cnt_load_i (cnt_load),
        .cnt_dat_i  (cnt_dat),
        .cnt_dec_i  (cnt_dec),
        .sr_msb_o   (sr_msb),
        .cnt_zero_o (cnt_zero)
    );

    // Next-state and shifter control; everything past IDLE advances on clkEn ticks only.
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_dat  = '0;
        case (state_q)
            ST_IDLE: begin
                if (InValid) begin
                    sr_load = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (clkEn) state_d = ST_START;
            end
            ST_START: begin
                if (clkEn) begin
                    state_d  = ST_PORT;
                    cnt_load = 1'b1;
                    cnt_dat  = CNT_W'(PORT_W - 1);
                end
            end
            ST_PORT: begin
                if (clkEn) begin
                    sr_shift = 1'b1;
                    if (cnt_zero) begin
                        state_d  = ST_LEN;
                        cnt_load = 1'b1;
                        cnt_dat  = CNT_W'(LEN_W - 1);
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            ST_LEN: begin
                if (clkEn) begin
                    sr_shift = 1'b1;
                    if (cnt_zero) begin
                        if (len_q != '0) begin
                            state_d  = ST_DATA;
                            cnt_load = 1'b1;
                            cnt_dat  = CNT_W'(len_q) - CNT_W'(1);
                        end else begin
                            state_d = after_payload;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (clkEn) begin
                    sr_shift = 1'b1;
                    if (cnt_zero) state_d = after_payload;
                    else          cnt_dec = 1'b1;
                end
            end
`ifdef SERTX_PARITY_EN
            ST_PAR: begin
                if (clkEn) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (clkEn) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, captured length and the end-of-frame pulse; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (accept) len_q <= LenIn;
        end
    end

    // Line level decoded from registered state only.
    always_comb begin
        SerOut = 1'b1;
        case (state_q)
            ST_START: SerOut = 1'b0;
            ST_PORT,
            ST_LEN,
            ST_DATA:  SerOut = sr_msb;
`ifdef SERTX_PARITY_EN
            ST_PAR:   SerOut = parity_q;
`endif
            default:  SerOut = 1'b1;
        endcase
    end

    assign InReady = (state_q == ST_IDLE);
    assign Busy    = (state_q != ST_IDLE);
    assign Done    = done_q;

endmodule
